// File: rtl/addr_seq.sv
// rtl/addr_seq.sv - Effective-address sequencer driving the AAL/AAH/AB address generator.
// Optional 24-bit pointer and long addressing (modes 9-12) enabled by ADDR_SEQ_LONG_EN.
module addr_seq (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       en_i,
  input  logic       start_i,
  input  logic [3:0] mode_i,
  input  logic       e6502_i,
  input  logic       dl_nz_i,
  input  logic       is_write_i,
  input  logic       aal_carry_i,
  output logic [7:0] addr_ctrl_o,
  output logic [1:0] ind_ctrl_o,
  output logic [2:0] load_pc_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] addr_sel_o
);

`ifdef ADDR_SEQ_LONG_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_OPL, S_OPH, S_DPW, S_IDX, S_PGX, S_PTL, S_PTH, S_FIN
`ifdef ADDR_SEQ_LONG_EN
    , S_OPB, S_PTB
`endif
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] mode_q, mode_d;
  logic       is_write_q, is_write_d;
  logic       e6502_q, e6502_d;
  logic       dl_nz_q, dl_nz_d;
  logic       imm_q, imm_d;

  logic m_abslong, m_long, m_dp, m_ptr, m_xi, m_yi, m_pre, m_post, m_pgx, m_wrap;
  logic start_imm;
  state_e after_dp;

  always_comb begin
    m_long    = (mode_q == 4'd11) || (mode_q == 4'd12);
    m_abslong = (mode_q <= 4'd2) || m_long;
    m_dp      = (mode_q >= 4'd3) && (mode_q <= 4'd10);
    m_ptr     = ((mode_q >= 4'd6) && (mode_q <= 4'd10)) || (mode_q == 4'd14);
    m_xi      = (mode_q == 4'd1) || (mode_q == 4'd4) || (mode_q == 4'd8) || (mode_q == 4'd12);
    m_yi      = (mode_q == 4'd2) || (mode_q == 4'd5) || (mode_q == 4'd7) ||
                (mode_q == 4'd10) || (mode_q == 4'd14);
    m_pre     = (mode_q == 4'd8);
    m_post    = (mode_q == 4'd7) || (mode_q == 4'd10) || (mode_q == 4'd14);
    m_pgx     = (mode_q == 4'd1) || (mode_q == 4'd2) || (mode_q == 4'd7);
    m_wrap    = ((mode_q == 4'd4) || (mode_q == 4'd5)) && e6502_q && !dl_nz_q;
    start_imm = (mode_i == 4'd15) || (!LONG_EN && (mode_i >= 4'd9) && (mode_i <= 4'd12));
    // Shared exit from OPL/DPW for direct-page and stack-relative modes
    if (m_ptr && !m_pre)  after_dp = S_PTL;
    else if (m_xi | m_yi) after_dp = S_IDX;
    else                  after_dp = S_FIN;
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    is_write_d = is_write_q;
    e6502_d    = e6502_q;
    dl_nz_d    = dl_nz_q;
    imm_d      = imm_q;
    if (en_i) begin
      imm_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (start_imm) begin
              imm_d = 1'b1;
            end else begin
              state_d    = S_OPL;
              mode_d     = mode_i;
              is_write_d = is_write_i;
              e6502_d    = e6502_i;
              dl_nz_d    = dl_nz_i;
            end
          end
        end
        S_OPL: begin
          if (m_abslong)             state_d = S_OPH;
          else if (m_dp && dl_nz_q)  state_d = S_DPW;
          else                       state_d = after_dp;
        end
        S_DPW: state_d = after_dp;
        S_OPH: begin
`ifdef ADDR_SEQ_LONG_EN
          if (m_long)             state_d = S_OPB;
          else
`endif
          if (m_xi | m_yi)        state_d = S_IDX;
          else                    state_d = S_FIN;
        end
        S_IDX: begin
          if (m_pre)              state_d = S_PTL;
          else if (m_pgx && (aal_carry_i || is_write_q || !e6502_q)) state_d = S_PGX;
          else                    state_d = S_FIN;
        end
        S_PGX: state_d = S_FIN;
        S_PTL: state_d = S_PTH;
        S_PTH: begin
`ifdef ADDR_SEQ_LONG_EN
          if ((mode_q == 4'd9) || (mode_q == 4'd10)) state_d = S_PTB;
          else
`endif
          if (m_post)             state_d = S_IDX;
          else                    state_d = S_FIN;
        end
`ifdef ADDR_SEQ_LONG_EN
        S_OPB: state_d = (m_xi | m_yi) ? S_IDX : S_FIN;
        S_PTB: state_d = m_post ? S_IDX : S_FIN;
`endif
        S_FIN: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      mode_q     <= 4'd0;
      is_write_q <= 1'b0;
      e6502_q    <= 1'b0;
      dl_nz_q    <= 1'b0;
      imm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      is_write_q <= is_write_d;
      e6502_q    <= e6502_d;
      dl_nz_q    <= dl_nz_d;
      imm_q      <= imm_d;
    end
  end

  // ADDR_CTRL fields: {AAL[2:0], AAH[2:0], AB[1:0]}
  always_comb begin
    addr_ctrl_o = 8'h00;
    ind_ctrl_o  = 2'b00;
    load_pc_o   = 3'b000;
    addr_sel_o  = 2'd0;
    busy_o      = (state_q != S_IDLE);
    done_o      = (state_q == S_FIN) || imm_q;
    case (state_q)
      S_OPL: begin
        load_pc_o   = 3'b001;
        addr_ctrl_o = m_abslong ? {3'b010, 3'b000, 2'b11} : {3'b101, 3'b101, 2'b00};
      end
      S_OPH: addr_ctrl_o = {3'b000, 3'b010, 2'b00};
      S_IDX: begin
        addr_ctrl_o = m_wrap ? {3'b100, 3'b100, 2'b00} : {3'b001, 3'b001, 2'b00};
        ind_ctrl_o  = m_yi ? 2'b01 : 2'b00;
      end
      S_PTL: begin
        addr_sel_o  = 2'd1;
        addr_ctrl_o = {3'b010, 3'b000, 2'b00};
      end
      S_PTH: begin
        addr_sel_o  = 2'd1;
        addr_ctrl_o = {3'b000, 3'b010, 2'b11};
      end
`ifdef ADDR_SEQ_LONG_EN
      S_OPB: addr_ctrl_o = {3'b000, 3'b000, 2'b01};
      S_PTB: begin
        addr_sel_o  = 2'd1;
        addr_ctrl_o = {3'b000, 3'b000, 2'b01};
      end
`endif
      S_FIN: addr_sel_o = 2'd2;
      default: ;
    endcase
  end

endmodule
